ft600_bus_responder: RTL and testbench
======================================

Name: ft600_bus_responder

Overview:
- Synthesizable device-side model of the FT600 245-style synchronous FIFO bus: the chip end that the FPGA-side controller talks to.
- Holds a downstream FIFO (host→FPGA words, served on FPGA reads) and an upstream FIFO (FPGA→host words, captured from FPGA writes).
- Drives ft_txe/ft_rxf flags and read data, and exposes both FIFOs as valid/ready streams.
- Used for loopback benches and on-board self-test of the FT600 controller, without the physical chip.

Parameters:
DOWN_DEPTH_LOG2, 4, downstream FIFO depth = 2^N words (16-bit)
UP_DEPTH_LOG2, 4, upstream FIFO depth = 2^N entries (16-bit data + 2-bit be)

Ports:
clk  in  1  single clock; bus and stream side share it
rst_n  in  1  asynchronous active-low reset
down_data  in  16  host word to deliver to FPGA
down_valid  in  1  down_data valid
down_ready  out  1  downstream FIFO not full
up_data  out  16  word captured from FPGA write
up_be  out  2  byte enables captured with up_data
up_valid  out  1  upstream FIFO not empty
up_ready  in  1  consumer accepts up_data
ft_data_i  in  16  bus data from FPGA (pad input)
ft_be_i  in  2  bus byte enables from FPGA
ft_data_o  out  16  read data toward FPGA
ft_be_o  out  2  read byte enables, constant 2'b11
ft_data_oe  out  1  pad drive enable for ft_data_o/ft_be_o
ft_txe  out  1  active-low: upstream FIFO has space
ft_rxf  out  1  active-low: downstream FIFO has data
ft_oe  in  1  active-low FPGA output-enable request
ft_rd  in  1  active-low read strobe
ft_wr  in  1  active-low write strobe
err_overrun  out  1  sticky: write strobe while ft_txe high
err_underrun  out  1  sticky: read strobe while ft_rxf high
err_contention  out  1  sticky: ft_oe and ft_wr both low

Behaviour:
- Reset (async, rst_n=0): both FIFOs empty, pointers/counts 0, ft_txe=1, ft_rxf=1, all err_*=0, down_ready=0, up_valid=0. ft_data_oe=0 whenever ft_oe=1, so also 0 in reset.
- ft_txe and ft_rxf are registered from next-state counts:
  - ft_txe <= (up_count_next == UP depth).
  - ft_rxf <= (down_count_next == 0).
  - First edge after reset release: ft_txe=0, ft_rxf=1.
- down_ready = !down_full and up_valid = !up_empty, both from registered counts. down_ready goes 1 one cycle after reset release.
- Downstream push: edge with down_valid & down_ready.
- Downstream pop: edge with ft_oe=0 & ft_rd=0 & ft_rxf=0.
- Upstream push: edge with ft_wr=0 & ft_txe=0 & ft_oe=1. Stores {ft_be_i, ft_data_i} as-is, including be=00.
- Upstream pop: edge with up_valid & up_ready.
- Push and pop on the same FIFO in one cycle are both performed; count is unchanged. A pop empties the FIFO only via pops; a push at full cannot occur because it is gated by ready/flag.
- Read path:
  - ft_data_oe = !ft_oe.
  - ft_data_o = downstream head word, combinational from the read pointer.
  - After a pop, the next word appears the following cycle.
  - Popping the last word sets ft_rxf=1 on that same edge.
  - While ft_oe=0 and ft_rxf=1, ft_data_o is don't-care but still driven.
- Back-to-back: ft_rd held low for N cycles with ft_rxf=0 pops N words, one per edge, with no gaps.
- Errors (each set on the offending edge, cleared only by reset; offending transfer is ignored):
  - ft_rd=0 & ft_oe=0 & ft_rxf=1 → err_underrun.
  - ft_wr=0 & ft_txe=1 → err_overrun.
  - ft_wr=0 & ft_oe=0 → err_contention. The write is not stored even if ft_txe=0.
- Pointers wrap modulo depth. Counts are DEPTH_LOG2+1 bits wide.
- Reset mid-burst: all contents are discarded, flags return to 1 immediately (async), and in-progress strobes are ignored until release.

Test Plan:
- Reset release with idle bus → 1 cycle later: ft_txe=0, ft_rxf=1, down_ready=1, up_valid=0, err_*=0, ft_data_oe=0.
- Push 0x1111, 0x2222, 0x3333 downstream; FPGA drives ft_oe=0, then ft_rd=0 for 3 edges → ft_data_o reads 0x1111, 0x2222, 0x3333 on successive edges; ft_rxf=1 after the 3rd pop edge; ft_be_o=2'b11; no errors.
- FPGA writes 16 words 0x0000..0x000F (be=11) with up_ready=0 → ft_txe=1 after the 16th edge. A 17th write sets err_overrun=1, and the FIFO still holds 16 entries. Draining with up_ready=1 returns 0x0000..0x000F in order.
- Sustained streaming: simultaneous upstream write and drain for 40 cycles at depth 16 → ft_txe stays 0, all 40 words are in order, and pointers wrap correctly.
- ft_oe=0 with ft_wr=0 (data 0xBEEF) → err_contention=1, no upstream entry. ft_rd=0 on an empty FIFO → err_underrun=1.
- rst_n pulsed low mid-way through an 8-word read burst → ft_rxf=1 asynchronously and FIFO empty. After release, new pushed data 0xA5A5 is the first word read.

Source files
------------

// File: rtl/ft600_bus_responder.sv
// FT600 245-style synchronous FIFO bus, device side.
// Plays the chip end of the bus so the FPGA-side controller can be
// exercised in loopback or on-board self-test without the real part.
// Downstream FIFO: host words pushed on the stream side, served on FPGA reads.
// Upstream FIFO: FPGA bus writes captured, drained on the stream side.

// Simple synchronous FIFO with exposed occupancy and next-state occupancy.
// Callers gate push/pop so that push-at-full and pop-at-empty never occur.
module ft600_resp_fifo #(
    parameter int W          = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [W-1:0]          wdata,
    output logic [W-1:0]          rdata,
    output logic [DEPTH_LOG2:0]   count,
    output logic [DEPTH_LOG2:0]   count_next
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [W-1:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;

    // Head word is read combinationally so it is valid the cycle after a pop.
    assign rdata = mem[rd_ptr];

    // Occupancy after this edge; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_next = count;
        if (push && !pop)
            count_next = count + 1'b1;
        else if (!push && pop)
            count_next = count - 1'b1;
    end

    // Storage array carries no reset: contents are meaningless once pointers clear.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally modulo depth; count tracks occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_next;
        end
    end
endmodule

module ft600_bus_responder #(
    parameter int DOWN_DEPTH_LOG2 = 4,
    parameter int UP_DEPTH_LOG2   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    // downstream stream (host -> FPGA)
    input  logic [15:0] down_data,
    input  logic        down_valid,
    output logic        down_ready,
    // upstream stream (FPGA -> host)
    output logic [15:0] up_data,
    output logic [1:0]  up_be,
    output logic        up_valid,
    input  logic        up_ready,
    // FT600 bus
    input  logic [15:0] ft_data_i,
    input  logic [1:0]  ft_be_i,
    output logic [15:0] ft_data_o,
    output logic [1:0]  ft_be_o,
    output logic        ft_data_oe,
    output logic        ft_txe,
    output logic        ft_rxf,
    input  logic        ft_oe,
    input  logic        ft_rd,
    input  logic        ft_wr,
    // sticky protocol errors
    output logic        err_overrun,
    output logic        err_underrun,
    output logic        err_contention
);
    localparam int DOWN_DEPTH = 1 << DOWN_DEPTH_LOG2;
    localparam int UP_DEPTH   = 1 << UP_DEPTH_LOG2;

    typedef struct packed {
        logic [1:0]  be;
        logic [15:0] data;
    } up_entry_t;

    logic [DOWN_DEPTH_LOG2:0] down_count;
    logic [DOWN_DEPTH_LOG2:0] down_count_next;
    logic [UP_DEPTH_LOG2:0]   up_count;
    logic [UP_DEPTH_LOG2:0]   up_count_next;

    logic      down_push;
    logic      down_pop;
    logic      up_push;
    logic      up_pop;
    up_entry_t up_wentry;
    up_entry_t up_rentry;

    logic rd_strobe;
    logic wr_strobe;
    logic bus_driving;

    // Bus strobes are active low; decode them once.
    assign rd_strobe   = !ft_rd;
    assign wr_strobe   = !ft_wr;
    assign bus_driving = !ft_oe;

    // Transfers qualify only against the registered flags the FPGA actually sees.
    // A write while the FPGA has asked us to drive is contention and is dropped.
    assign down_push = down_valid && down_ready;
    assign down_pop  = bus_driving && rd_strobe && !ft_rxf;
    assign up_push   = wr_strobe && !ft_txe && !bus_driving;
    assign up_pop    = up_valid && up_ready;

    assign up_wentry = '{be: ft_be_i, data: ft_data_i};

    ft600_resp_fifo #(
        .W          (16),
        .DEPTH_LOG2 (DOWN_DEPTH_LOG2)
    ) u_down_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (down_push),
        .pop        (down_pop),
        .wdata      (down_data),
        .rdata      (ft_data_o),
        .count      (down_count),
        .count_next (down_count_next)
    );

    ft600_resp_fifo #(
        .W          ($bits(up_entry_t)),
        .DEPTH_LOG2 (UP_DEPTH_LOG2)
    ) u_up_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (up_push),
        .pop        (up_pop),
        .wdata      (up_wentry),
        .rdata      (up_rentry),
        .count      (up_count),
        .count_next (up_count_next)
    );

    assign up_data    = up_rentry.data;
    assign up_be      = up_rentry.be;
    assign up_valid   = (up_count != '0);

    // Read data is always full-word; the pads drive only while the FPGA asks.
    assign ft_be_o    = 2'b11;
    assign ft_data_oe = bus_driving;

    // Bus flags and down_ready come from next-state counts so a pop of the
    // last word raises ft_rxf on that same edge. down_ready is held low in
    // reset and rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ft_txe     <= 1'b1;
            ft_rxf     <= 1'b1;
            down_ready <= 1'b0;
        end else begin
            ft_txe     <= (up_count_next == (UP_DEPTH_LOG2+1)'(UP_DEPTH));
            ft_rxf     <= (down_count_next == '0);
            down_ready <= (down_count_next != (DOWN_DEPTH_LOG2+1)'(DOWN_DEPTH));
        end
    end

    // Sticky protocol error flags; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_overrun    <= 1'b0;
            err_underrun   <= 1'b0;
            err_contention <= 1'b0;
        end else begin
            if (wr_strobe && ft_txe)
                err_overrun <= 1'b1;
            if (rd_strobe && bus_driving && ft_rxf)
                err_underrun <= 1'b1;
            if (wr_strobe && bus_driving)
                err_contention <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ft600_bus_responder.sv
// Self-checking bench for ft600_bus_responder: scoreboard queues hold the
// words expected out of each FIFO; inputs change and outputs are sampled
// on the falling clock edge.
module tb_ft600_bus_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] down_data;
    logic        down_valid;
    logic        down_ready;
    logic [15:0] up_data;
    logic [1:0]  up_be;
    logic        up_valid;
    logic        up_ready;
    logic [15:0] ft_data_i;
    logic [1:0]  ft_be_i;
    logic [15:0] ft_data_o;
    logic [1:0]  ft_be_o;
    logic        ft_data_oe;
    logic        ft_txe;
    logic        ft_rxf;
    logic        ft_oe;
    logic        ft_rd;
    logic        ft_wr;
    logic        err_overrun;
    logic        err_underrun;
    logic        err_contention;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] down_q [$];
    logic [17:0] up_q   [$];

    always #5 clk = ~clk;

    ft600_bus_responder #(.DOWN_DEPTH_LOG2(4), .UP_DEPTH_LOG2(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .down_data(down_data), .down_valid(down_valid), .down_ready(down_ready),
        .up_data(up_data), .up_be(up_be), .up_valid(up_valid), .up_ready(up_ready),
        .ft_data_i(ft_data_i), .ft_be_i(ft_be_i),
        .ft_data_o(ft_data_o), .ft_be_o(ft_be_o), .ft_data_oe(ft_data_oe),
        .ft_txe(ft_txe), .ft_rxf(ft_rxf),
        .ft_oe(ft_oe), .ft_rd(ft_rd), .ft_wr(ft_wr),
        .err_overrun(err_overrun), .err_underrun(err_underrun),
        .err_contention(err_contention)
    );

    task automatic test_reset();
        @(negedge clk);
        n_vec++;
        if ({ft_txe, ft_rxf, down_ready, up_valid, ft_data_oe} !== 5'b11000) begin
            n_err++;
            $display("FAIL reset_hold: txe,rxf,drdy,uvld,oe got %b want 11000",
                     {ft_txe, ft_rxf, down_ready, up_valid, ft_data_oe});
        end
        n_vec++;
        if ({err_overrun, err_underrun, err_contention} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_err: got %b want 000", {err_overrun, err_underrun, err_contention});
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({ft_txe, ft_rxf, down_ready, up_valid, ft_data_oe} !== 5'b01100) begin
            n_err++;
            $display("FAIL reset_release: txe,rxf,drdy,uvld,oe got %b want 01100",
                     {ft_txe, ft_rxf, down_ready, up_valid, ft_data_oe});
        end
        n_vec++;
        if ({err_overrun, err_underrun, err_contention} !== 3'b000) begin
            n_err++;
            $display("FAIL release_err: got %b want 000", {err_overrun, err_underrun, err_contention});
        end
    endtask

    task automatic test_down_read();
        logic [15:0] words [3];
        logic [15:0] exp;
        words = '{16'h1111, 16'h2222, 16'h3333};
        for (int i = 0; i < 3; i++) begin
            down_valid = 1'b1;
            down_data  = words[i];
            down_q.push_back(words[i]);
            @(negedge clk);
        end
        down_valid = 1'b0;
        n_vec++;
        if (ft_rxf !== 1'b0) begin
            n_err++;
            $display("FAIL down_rxf_low: got %b want 0", ft_rxf);
        end
        ft_oe = 1'b0;
        @(negedge clk);
        n_vec++;
        if (ft_data_oe !== 1'b1 || ft_be_o !== 2'b11) begin
            n_err++;
            $display("FAIL down_oe_be: oe=%b be=%b want 1/11", ft_data_oe, ft_be_o);
        end
        ft_rd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp = down_q.pop_front();
            n_vec++;
            if (ft_data_o !== exp) begin
                n_err++;
                $display("FAIL down_read[%0d]: got %h want %h", i, ft_data_o, exp);
            end
            @(negedge clk);
        end
        ft_rd = 1'b1;
        ft_oe = 1'b1;
        n_vec++;
        if (ft_rxf !== 1'b1) begin
            n_err++;
            $display("FAIL down_rxf_empty: got %b want 1", ft_rxf);
        end
        n_vec++;
        if ({err_overrun, err_underrun, err_contention} !== 3'b000) begin
            n_err++;
            $display("FAIL down_no_err: got %b want 000", {err_overrun, err_underrun, err_contention});
        end
    endtask

    task automatic test_up_overrun();
        logic [17:0] exp;
        up_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            n_vec++;
            if (ft_txe !== 1'b0) begin
                n_err++;
                $display("FAIL up_txe_space[%0d]: got %b want 0", i, ft_txe);
            end
            ft_wr     = 1'b0;
            ft_data_i = 16'(i);
            ft_be_i   = 2'b11;
            up_q.push_back({2'b11, 16'(i)});
            @(negedge clk);
        end
        n_vec++;
        if (ft_txe !== 1'b1) begin
            n_err++;
            $display("FAIL up_txe_full: got %b want 1", ft_txe);
        end
        ft_data_i = 16'h0010;
        @(negedge clk);
        ft_wr = 1'b1;
        n_vec++;
        if (err_overrun !== 1'b1) begin
            n_err++;
            $display("FAIL up_overrun: got %b want 1", err_overrun);
        end
        up_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp = up_q.pop_front();
            n_vec++;
            if (up_valid !== 1'b1 || {up_be, up_data} !== exp) begin
                n_err++;
                $display("FAIL up_drain[%0d]: vld=%b got %h want %h", i, up_valid, {up_be, up_data}, exp);
            end
            @(negedge clk);
        end
        up_ready = 1'b0;
        n_vec++;
        if (up_valid !== 1'b0 || ft_txe !== 1'b0) begin
            n_err++;
            $display("FAIL up_drained: vld=%b txe=%b want 0/0", up_valid, ft_txe);
        end
    endtask

    task automatic test_streaming();
        logic [17:0] exp;
        int popped = 0;
        up_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            ft_wr     = 1'b0;
            ft_data_i = 16'h0100 + 16'(i);
            ft_be_i   = 2'(i);
            up_q.push_back({2'(i), 16'h0100 + 16'(i)});
            n_vec++;
            if (ft_txe !== 1'b0) begin
                n_err++;
                $display("FAIL stream_txe[%0d]: got %b want 0", i, ft_txe);
            end
            if (up_valid === 1'b1) begin
                exp = up_q.pop_front();
                popped++;
                n_vec++;
                if ({up_be, up_data} !== exp) begin
                    n_err++;
                    $display("FAIL stream_word[%0d]: got %h want %h", popped, {up_be, up_data}, exp);
                end
            end
            @(negedge clk);
        end
        ft_wr = 1'b1;
        for (int k = 0; k < 40 && up_q.size() > 0; k++) begin
            if (up_valid === 1'b1) begin
                exp = up_q.pop_front();
                popped++;
                n_vec++;
                if ({up_be, up_data} !== exp) begin
                    n_err++;
                    $display("FAIL stream_tail[%0d]: got %h want %h", popped, {up_be, up_data}, exp);
                end
            end
            @(negedge clk);
        end
        up_ready = 1'b0;
        n_vec++;
        if (popped != 40 || up_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stream_count: popped %0d vld=%b want 40/0", popped, up_valid);
        end
        up_q.delete();
    endtask

    task automatic test_errors();
        ft_oe     = 1'b0;
        ft_wr     = 1'b0;
        ft_data_i = 16'hBEEF;
        ft_be_i   = 2'b11;
        @(negedge clk);
        ft_wr = 1'b1;
        ft_oe = 1'b1;
        n_vec++;
        if (err_contention !== 1'b1 || up_valid !== 1'b0) begin
            n_err++;
            $display("FAIL contention: err=%b vld=%b want 1/0", err_contention, up_valid);
        end
        n_vec++;
        if (err_underrun !== 1'b0) begin
            n_err++;
            $display("FAIL underrun_pre: got %b want 0", err_underrun);
        end
        ft_oe = 1'b0;
        ft_rd = 1'b0;
        @(negedge clk);
        ft_rd = 1'b1;
        ft_oe = 1'b1;
        n_vec++;
        if (err_underrun !== 1'b1 || ft_rxf !== 1'b1) begin
            n_err++;
            $display("FAIL underrun: err=%b rxf=%b want 1/1", err_underrun, ft_rxf);
        end
    endtask

    task automatic test_reset_midburst();
        logic [15:0] exp;
        for (int i = 0; i < 8; i++) begin
            down_valid = 1'b1;
            down_data  = 16'h0800 + 16'(i);
            down_q.push_back(16'h0800 + 16'(i));
            @(negedge clk);
        end
        down_valid = 1'b0;
        ft_oe = 1'b0;
        @(negedge clk);
        ft_rd = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp = down_q.pop_front();
            n_vec++;
            if (ft_data_o !== exp) begin
                n_err++;
                $display("FAIL burst_read[%0d]: got %h want %h", i, ft_data_o, exp);
            end
            @(negedge clk);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({ft_rxf, ft_txe, down_ready} !== 3'b110) begin
            n_err++;
            $display("FAIL midburst_async: rxf,txe,drdy got %b want 110", {ft_rxf, ft_txe, down_ready});
        end
        n_vec++;
        if ({err_overrun, err_underrun, err_contention} !== 3'b000) begin
            n_err++;
            $display("FAIL midburst_err_clr: got %b want 000", {err_overrun, err_underrun, err_contention});
        end
        down_q.delete();
        @(negedge clk);
        ft_rd = 1'b1;
        ft_oe = 1'b1;
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (ft_rxf !== 1'b1 || down_ready !== 1'b1) begin
            n_err++;
            $display("FAIL post_reset: rxf=%b drdy=%b want 1/1", ft_rxf, down_ready);
        end
        down_valid = 1'b1;
        down_data  = 16'hA5A5;
        down_q.push_back(16'hA5A5);
        @(negedge clk);
        down_valid = 1'b0;
        n_vec++;
        if (ft_rxf !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_rxf: got %b want 0", ft_rxf);
        end
        ft_oe = 1'b0;
        ft_rd = 1'b0;
        exp = down_q.pop_front();
        n_vec++;
        if (ft_data_o !== exp) begin
            n_err++;
            $display("FAIL post_reset_word: got %h want %h", ft_data_o, exp);
        end
        @(negedge clk);
        ft_rd = 1'b1;
        ft_oe = 1'b1;
        n_vec++;
        if (ft_rxf !== 1'b1 || err_underrun !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_empty: rxf=%b underrun=%b want 1/0", ft_rxf, err_underrun);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        down_data  = '0;
        down_valid = 1'b0;
        up_ready   = 1'b0;
        ft_data_i  = '0;
        ft_be_i    = 2'b11;
        ft_oe      = 1'b1;
        ft_rd      = 1'b1;
        ft_wr      = 1'b1;
        test_reset();
        test_down_read();
        test_up_overrun();
        test_streaming();
        test_errors();
        test_reset_midburst();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Safety net: the bench must end even if something stalls.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want finish before 200000");
        $fatal(1);
    end
endmodule
